// File: rtl/serpent_xts_pkg.sv
// ============================================================================
// serpent_xts_pkg : shared constants and state type for the XTS tweak generator
// Revision: 1.0
// ============================================================================
`default_nettype none

package serpent_xts_pkg;

  localparam int        XTS_BLK_W   = 128;
  localparam logic [7:0] XTS_GF_POLY = 8'h87;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } xts_state_t;

endpackage

`default_nettype wire

// File: rtl/serpent_xts_gf_mul_alpha.sv
// ============================================================================
// serpent_xts_gf_mul_alpha : combinational GF(2^128) doubling in XTS byte order
// Revision: 1.0
// ============================================================================
`default_nettype none

module serpent_xts_gf_mul_alpha
  import serpent_xts_pkg::*;
(
  input  logic [XTS_BLK_W-1:0] data,
  output logic [XTS_BLK_W-1:0] doubled
);

  // Byte k sits at bits [127-8k -: 8]; byte 0 is least significant in GF terms.
  assign doubled[127 -: 8] = {data[126:120], 1'b0} ^ (data[7] ? XTS_GF_POLY : 8'h00);

  for (genvar k = 1; k < 16; k++) begin : g_byte
    assign doubled[127-8*k -: 8] = {data[126-8*k -: 7], data[135-8*k]};
  end

endmodule

`default_nettype wire

// File: rtl/serpent_xts_tweak_gen.sv
// ============================================================================
// serpent_xts_tweak_gen : issues XTS tweaks T0..Tn-1 with valid/ready handshake
// Optional: define SERPENT_XTS_ABORT_EN to add the i_abort port.   Revision: 1.0
// ============================================================================
`default_nettype none

module serpent_xts_tweak_gen
  import serpent_xts_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [XTS_BLK_W-1:0] i_tweak_enc,
  input  logic                 i_tweak_enc_valid,
  input  logic [CNT_W-1:0]     i_num_blocks,
  input  logic                 i_tweak_ready,
`ifdef SERPENT_XTS_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic [XTS_BLK_W-1:0] o_tweak,
  output logic                 o_tweak_valid,
  output logic                 o_tweak_last,
  output logic [CNT_W-1:0]     o_block_idx,
  output logic                 o_busy,
  output logic                 o_err
);

  xts_state_t           state;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     idx_next;
  logic [CNT_W-1:0]     count_m1;
  logic [XTS_BLK_W-1:0] tweak_dbl;

  serpent_xts_gf_mul_alpha u_mul_alpha (
    .data    (o_tweak),
    .doubled (tweak_dbl)
  );

  assign idx_next = o_block_idx + CNT_W'(1);
  assign count_m1 = count - CNT_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      count         <= '0;
      o_tweak       <= '0;
      o_tweak_valid <= 1'b0;
      o_tweak_last  <= 1'b0;
      o_block_idx   <= '0;
      o_busy        <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      o_err <= 1'b0;
      case (state)
        IDLE: begin
          if (i_tweak_enc_valid) begin
            if (i_num_blocks != '0) begin
              state         <= RUN;
              count         <= i_num_blocks;
              o_tweak       <= i_tweak_enc;
              o_block_idx   <= '0;
              o_tweak_valid <= 1'b1;
              o_tweak_last  <= (i_num_blocks == CNT_W'(1));
              o_busy        <= 1'b1;
            end else begin
              o_err <= 1'b1;
            end
          end
        end
        RUN: begin
          // A new tweak arriving mid-sequence is discarded and flagged.
          if (i_tweak_enc_valid) begin
            o_err <= 1'b1;
          end
`ifdef SERPENT_XTS_ABORT_EN
          if (i_abort) begin
            state         <= IDLE;
            o_tweak_valid <= 1'b0;
            o_tweak_last  <= 1'b0;
            o_busy        <= 1'b0;
          end else
`endif
          if (i_tweak_ready) begin
            if (o_block_idx == count_m1) begin
              state         <= IDLE;
              o_tweak_valid <= 1'b0;
              o_tweak_last  <= 1'b0;
              o_busy        <= 1'b0;
            end else begin
              o_tweak      <= tweak_dbl;
              o_block_idx  <= idx_next;
              o_tweak_last <= (idx_next == count_m1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serpent_xts_tweak_gen.sv
// ============================================================================
// tb_serpent_xts_tweak_gen : scoreboard bench for the XTS tweak generator
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serpent_xts_tweak_gen;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [127:0]     tweak_enc;
  logic             tweak_enc_valid;
  logic [CNT_W-1:0] num_blocks;
  logic             tweak_ready;
`ifdef SERPENT_XTS_ABORT_EN
  logic             abort;
`endif
  logic [127:0]     o_tweak;
  logic             o_tweak_valid;
  logic             o_tweak_last;
  logic [CNT_W-1:0] o_block_idx;
  logic             o_busy;
  logic             o_err;

  typedef struct packed {
    logic [127:0]     tw;
    logic [CNT_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serpent_xts_tweak_gen #(.CNT_W(CNT_W)) dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_tweak_enc       (tweak_enc),
    .i_tweak_enc_valid (tweak_enc_valid),
    .i_num_blocks      (num_blocks),
    .i_tweak_ready     (tweak_ready),
`ifdef SERPENT_XTS_ABORT_EN
    .i_abort           (abort),
`endif
    .o_tweak           (o_tweak),
    .o_tweak_valid     (o_tweak_valid),
    .o_tweak_last      (o_tweak_last),
    .o_block_idx       (o_block_idx),
    .o_busy            (o_busy),
    .o_err             (o_err)
  );

  // Reference: byte-swap to a little-endian integer, shift, reduce, swap back.
  function automatic logic [127:0] model_double(input logic [127:0] t);
    logic [127:0] le;
    logic [127:0] r;
    for (int k = 0; k < 16; k++) le[8*k +: 8] = t[127-8*k -: 8];
    le = {le[126:0], 1'b0} ^ (le[127] ? 128'h87 : 128'h0);
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = le[8*k +: 8];
    return r;
  endfunction

  task automatic load(input logic [127:0] t0, input int n);
    logic [127:0] t;
    t = t0;
    for (int j = 0; j < n; j++) begin
      sb.push_back('{tw: t, idx: CNT_W'(j), last: (j == n - 1)});
      t = model_double(t);
    end
    tweak_enc       = t0;
    num_blocks      = CNT_W'(n);
    tweak_enc_valid = 1'b1;
    @(posedge clk); #1;
    tweak_enc_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_tweak, o_tweak_valid, o_tweak_last, o_block_idx, o_busy, o_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tweak=%h v=%b l=%b idx=%0d busy=%b err=%b, want all 0",
               o_tweak, o_tweak_valid, o_tweak_last, o_block_idx, o_busy, o_err);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int hs = 0;
    int cyc = 0;
    exp_t e;
    tweak_ready = 1'b1;
    load({8'h01, 120'h0}, 4);
    checks++;
    if (o_tweak_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: valid=%b want 1", o_tweak_valid);
    end
    while (sb.size() != 0 && cyc < 20) begin
      if (o_tweak_valid && tweak_ready) begin
        e = sb.pop_front();
        checks++;
        if ({o_tweak, o_block_idx, o_tweak_last} !== {e.tw, e.idx, e.last} ||
            o_tweak[127:120] !== (8'h01 << hs)) begin
          errors++;
          $display("FAIL basic_tweak: got %h idx=%0d last=%b want %h idx=%0d last=%b",
                   o_tweak, o_block_idx, o_tweak_last, e.tw, e.idx, e.last);
        end
        hs++;
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (hs != 4 || cyc != 4) begin
      errors++;
      $display("FAIL basic_rate: got %0d handshakes in %0d cycles want 4 in 4", hs, cyc);
    end
    checks++;
    if (o_busy !== 1'b0 || o_tweak_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done: busy=%b valid=%b want 0 0", o_busy, o_tweak_valid);
    end
  endtask

  task automatic test_poly();
    logic [127:0] t0s  [2];
    logic [127:0] want [2];
    int cyc;
    exp_t e;
    t0s[0] = 128'h80;            want[0] = {8'h87, 120'h0};
    t0s[1] = {128{1'b1}};        want[1] = {8'h79, {120{1'b1}}};
    tweak_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      load(t0s[p], 2);
      cyc = 0;
      while (sb.size() != 0 && cyc < 10) begin
        if (o_tweak_valid) begin
          e = sb.pop_front();
          checks++;
          if ({o_tweak, o_block_idx, o_tweak_last} !== {e.tw, e.idx, e.last} ||
              (e.idx == 1 && o_tweak !== want[p])) begin
            errors++;
            $display("FAIL poly_tweak%0d: got %h idx=%0d want %h idx=%0d",
                     p, o_tweak, o_block_idx, e.tw, e.idx);
          end
        end
        cyc++;
        @(posedge clk); #1;
      end
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL poly_count%0d: %0d tweaks missing want 0", p, sb.size());
        sb.delete();
      end
    end
  endtask

  task automatic test_backpressure();
    logic pat [6];
    int hs = 0;
    exp_t e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tweak_ready = 1'b0;
    load({8'h5A, 112'h0123456789ABCDEF0011223344, 8'hC3}, 3);
    for (int c = 0; c < 8; c++) begin
      tweak_ready = (c < 6) ? pat[c] : 1'b0;
      if (o_tweak_valid && sb.size() != 0) begin
        checks++;
        if ({o_tweak, o_block_idx, o_tweak_last} !== {sb[0].tw, sb[0].idx, sb[0].last}) begin
          errors++;
          $display("FAIL bp_hold: cycle %0d got %h idx=%0d last=%b want %h idx=%0d last=%b",
                   c, o_tweak, o_block_idx, o_tweak_last, sb[0].tw, sb[0].idx, sb[0].last);
        end
        if (tweak_ready) begin
          e = sb.pop_front();
          hs++;
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (hs != 3 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_count: got %0d handshakes busy=%b want 3 busy=0", hs, o_busy);
    end
    sb.delete();
  endtask

  task automatic test_err();
    int cyc = 0;
    exp_t e;
    tweak_ready = 1'b0;
    load({8'h11, 112'h0, 8'h22}, 3);
    tweak_enc = {128{1'b1}}; num_blocks = 16'd9; tweak_enc_valid = 1'b1;
    @(posedge clk); #1;
    tweak_enc_valid = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_tweak_valid !== 1'b1 || o_tweak !== sb[0].tw || o_block_idx !== '0) begin
      errors++;
      $display("FAIL err_drop: err=%b valid=%b tweak=%h idx=%0d want 1 1 %h 0",
               o_err, o_tweak_valid, o_tweak, o_block_idx, sb[0].tw);
    end
    @(posedge clk); #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_width: err=%b want 0", o_err);
    end
    tweak_ready = 1'b1;
    while (sb.size() != 0 && cyc < 10) begin
      tweak_enc_valid = (sb.size() == 1);
      if (o_tweak_valid) begin
        e = sb.pop_front();
        checks++;
        if ({o_tweak, o_block_idx, o_tweak_last} !== {e.tw, e.idx, e.last}) begin
          errors++;
          $display("FAIL err_seq: got %h idx=%0d want %h idx=%0d", o_tweak, o_block_idx, e.tw, e.idx);
        end
      end
      cyc++;
      @(posedge clk); #1;
    end
    tweak_enc_valid = 1'b0;
    checks++;
    if (o_err !== 1'b1 || o_tweak_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL err_final: err=%b valid=%b busy=%b want 1 0 0", o_err, o_tweak_valid, o_busy);
    end
    load(128'h1234, 0);
    checks++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_tweak_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_zero: err=%b busy=%b valid=%b want 1 0 0", o_err, o_busy, o_tweak_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_zero_width: err=%b want 0", o_err);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    tweak_ready = 1'b1;
    load({8'h3C, 120'h0}, 4);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({o_tweak, o_tweak_valid, o_tweak_last, o_block_idx, o_busy, o_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs: tweak=%h v=%b idx=%0d busy=%b want all 0",
               o_tweak, o_tweak_valid, o_block_idx, o_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (o_tweak_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet: valid=%b want 0", o_tweak_valid);
    end
    load({8'h9D, 120'h1}, 2);
    for (int c = 0; c < 2; c++) begin
      e = sb.pop_front();
      checks++;
      if ({o_tweak_valid, o_tweak, o_block_idx, o_tweak_last} !== {1'b1, e.tw, e.idx, e.last}) begin
        errors++;
        $display("FAIL rstmid_reload: v=%b got %h idx=%0d want %h idx=%0d",
                 o_tweak_valid, o_tweak, o_block_idx, e.tw, e.idx);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef SERPENT_XTS_ABORT_EN
  task automatic test_abort();
    exp_t e;
    tweak_ready = 1'b1;
    load({8'h3C, 120'h0}, 4);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    checks++;
    if (o_tweak_valid !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_stop: valid=%b busy=%b want 0 0", o_tweak_valid, o_busy);
    end
    load({8'h21, 120'h0}, 1);
    e = sb.pop_front();
    checks++;
    if ({o_tweak_valid, o_tweak, o_block_idx, o_tweak_last} !== {1'b1, e.tw, e.idx, e.last}) begin
      errors++;
      $display("FAIL abort_reload: v=%b got %h idx=%0d want %h idx=%0d",
               o_tweak_valid, o_tweak, o_block_idx, e.tw, e.idx);
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back();
    exp_t e;
    tweak_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      load({8'h40 + 8'(r), 120'h7}, 1);
      e = sb.pop_front();
      checks++;
      if ({o_tweak_valid, o_tweak, o_block_idx, o_tweak_last} !== {1'b1, e.tw, e.idx, e.last}) begin
        errors++;
        $display("FAIL b2b_single%0d: v=%b got %h idx=%0d last=%b want %h 0 1",
                 r, o_tweak_valid, o_tweak, o_block_idx, o_tweak_last, e.tw);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b want 0", o_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    tweak_enc = '0;
    tweak_enc_valid = 1'b0;
    num_blocks = '0;
    tweak_ready = 1'b0;
`ifdef SERPENT_XTS_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_poly();
    test_backpressure();
    test_err();
    test_reset_mid();
`ifdef SERPENT_XTS_ABORT_EN
    test_abort();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
